ps2_key_history: RTL

//   Consumes scan-code bytes from the ps2_keyboard receiver FIFO through its ready/nextdata_n handshake.

---
 rtl/ps2_key_history.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ps2_key_history.sv
// Pops set-2 scan codes from the PS/2 receiver FIFO, parses E0/F0 prefixes,
// keeps a make-code history, tracks the held key and counts presses in BCD.
module ps2_key_history #(
    parameter int DEPTH         = 3,
    parameter int REPEAT_FILTER = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [7:0]                   kb_data,
    input  logic                         kb_ready,
    input  logic                         kb_overflow,
    output logic                         kb_nextdata_n,
    input  logic                         disp_mode,
    output logic [8*DEPTH-1:0]           hist,
    output logic [$clog2(DEPTH+1)-1:0]   hist_cnt,
    output logic                         key_down,
    output logic [7:0]                   key_code,
    output logic                         key_ext,
    output logic [7:0]                   press_cnt,
    output logic                         ovf_err,
    output logic [14*DEPTH-1:0]          hex
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {H_IDLE, H_POP, H_GAP} hs_t;
    typedef enum logic [1:0] {P_NORM, P_EXT, P_BRK, P_EXTBRK} ps_t;

    hs_t        hs_q, hs_d;
    ps_t        ps_q, ps_d;
    logic [7:0] byte_q;
    logic       do_make, do_break, ev_ext;
    logic       key_match, accept_make;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] != 4'd9)      bcd_inc = {v[7:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd9) bcd_inc = {v[7:4] + 4'd1, 4'd0};
        else                     bcd_inc = 8'h00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_q <= H_IDLE;
            ps_q <= P_NORM;
        end else begin
            hs_q <= hs_d;
            ps_q <= ps_d;
        end
    end

    always_comb begin
        hs_d = hs_q;
        case (hs_q)
            H_IDLE:  if (kb_ready) hs_d = H_POP;
            H_POP:   hs_d = H_GAP;
            H_GAP:   hs_d = H_IDLE;
            default: hs_d = H_IDLE;
        endcase
    end

    // The parser only advances in H_POP, on the byte captured in H_IDLE.
    always_comb begin
        ps_d     = ps_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        ev_ext   = 1'b0;
        if (hs_q == H_POP) begin
            case (ps_q)
                P_NORM: begin
                    if (byte_q == 8'hE0)      ps_d = P_EXT;
                    else if (byte_q == 8'hF0) ps_d = P_BRK;
                    else                      do_make = 1'b1;
                end
                P_EXT: begin
                    if (byte_q == 8'hF0)      ps_d = P_EXTBRK;
                    else if (byte_q == 8'hE0) ps_d = P_EXT;
                    else begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        ps_d    = P_NORM;
                    end
                end
                default: begin
                    ps_d     = P_NORM;
                    ev_ext   = (ps_q == P_EXTBRK);
                    do_break = (byte_q != 8'hE0) && (byte_q != 8'hF0);
                end
            endcase
        end
    end

    assign key_match   = key_down && (key_ext == ev_ext) && (key_code == byte_q);
    assign accept_make = do_make && !((REPEAT_FILTER != 0) && key_match);

    always_ff @(posedge clk) begin
        if (rst) begin
            kb_nextdata_n <= 1'b1;
            byte_q        <= '0;
            hist          <= '0;
            hist_cnt      <= '0;
            key_down      <= 1'b0;
            key_code      <= '0;
            key_ext       <= 1'b0;
            press_cnt     <= 8'h00;
            ovf_err       <= 1'b0;
        end else begin
            kb_nextdata_n <= !((hs_q == H_IDLE) && kb_ready);
            if ((hs_q == H_IDLE) && kb_ready)
                byte_q <= kb_data;
            if (kb_overflow)
                ovf_err <= 1'b1;
            if (accept_make) begin
                hist <= {hist[8*DEPTH-9:0], byte_q};
                if (hist_cnt != CW'(DEPTH))
                    hist_cnt <= hist_cnt + 1'b1;
                press_cnt <= bcd_inc(press_cnt);
                key_down  <= 1'b1;
                key_code  <= byte_q;
                key_ext   <= ev_ext;
            end else if (do_break && key_match) begin
                key_down <= 1'b0;
            end
        end
    end

    always_comb begin
        hex = '1;
        if (!disp_mode) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (k < 32'(hist_cnt)) begin
                    hex[14*k +: 7]   = seg7(hist[8*k +: 4]);
                    hex[14*k+7 +: 7] = seg7(hist[8*k+4 +: 4]);
                end
            end
        end else begin
            if (key_down) begin
                hex[6:0]  = seg7(key_code[3:0]);
                hex[13:7] = seg7(key_code[7:4]);
            end
            hex[20:14] = seg7(press_cnt[3:0]);
            hex[27:21] = seg7(press_cnt[7:4]);
        end
    end

endmodule
